im_loader: RTL

- Write-side companion to the instruction ROM: receives a program image as a byte stream and writes it word-by-word into a writable instruction memory.
- The memory is addressed exactly as the fetch side reads it: byte address, word index = addr >> 2.
- Sits between a byte source (UART RX / testbench) and the instruction memory write port.
- Holds the CPU in reset (`cpu_hold`) while loading; releases it when the image is complete so execution starts at address 0.

---
 rtl/im_loader_pkg.sv | 23 ++
 rtl/im_loader_word_assembler.sv | 56 +++++
 rtl/im_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/im_loader_pkg.sv
// -----------------------------------------------------------------------------
// im_loader_pkg
// Shared definitions for the instruction-memory loader. It holds the loader
// state encoding and the framing constants of the program image: a
// little-endian header followed by little-endian 32-bit words.
// -----------------------------------------------------------------------------
package im_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    // The header carries the word count N, low byte first.
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// im_loader_word_assembler
// Builds 32-bit little-endian words from a byte stream. Each byte is steered
// into a lane chosen by the byte counter. On the fourth byte, word_ready
// pulses while that byte is still on byte_in. The word is presented
// combinationally so the caller can register it on that same edge.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clear       restart at lane 0 (start of a session)
//   byte_valid  byte_in is accepted this cycle
//   byte_in     incoming byte
//   word        assembled word (valid while word_ready is high)
//   word_ready  the fourth byte of a word is being accepted this cycle
// -----------------------------------------------------------------------------
module im_loader_word_assembler
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  byte_cnt;
    logic [23:0] low_bytes;   // lanes 0..2; lane 3 comes straight from byte_in

    // NOTE: sequential state uses non-blocking (<=) assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    // NOTE: this lane register is a handful of flops, not a memory array, so
    // it is cleared on reset like every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= '0;
            low_bytes <= '0;
        end else if (clear) begin
            byte_cnt  <= '0;
        end else if (byte_valid) begin
            case (byte_cnt)
                2'd0:    low_bytes[7:0]   <= byte_in;
                2'd1:    low_bytes[15:8]  <= byte_in;
                2'd2:    low_bytes[23:16] <= byte_in;
                default: ;
            endcase
            // After lane 3, the counter wraps to 0, ready for the next word.
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word       = {byte_in, low_bytes};
    assign word_ready = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
// Receives a program image as a byte stream and writes it into the
// instruction memory one word at a time. The image is a 16-bit word count N
// followed by N little-endian words. The CPU is held in reset while the load
// runs. It is released once all N words are written, so execution starts
// at address 0.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      pulse; begins a load session from IDLE, DONE or ERROR
//   rx_data    incoming byte
//   rx_valid   rx_data is valid this cycle
//   rx_ready   loader accepts a byte this cycle
//   im_we      instruction-memory write enable, one-cycle pulse per word
//   im_addr    word-aligned byte address of the write
//   im_wd      write data
//   cpu_hold   core held in reset while loading or after a rejected image
//   done       level; image fully written
//   error      level; header word count exceeds DEPTH_WORDS
// -----------------------------------------------------------------------------
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wd,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t                   state, state_next;
    logic [HDR_BYTES*8-1:0]   n_words;
    logic [ADDR_W-3:0]        word_cnt;
    logic [ADDR_W-3:0]        word_cnt_inc;
    logic [HDR_BYTES*8-1:0]   n_hdr;
    logic                     start_ok;
    logic                     last_word;
    logic                     data_xfer;
    logic [31:0]              word;
    logic                     word_ready;

    // Full count as it will look once the high header byte is latched.
    assign n_hdr        = {rx_data, n_words[7:0]};
    assign start_ok     = start && (state == IDLE || state == DONE || state == ERROR);
    assign data_xfer    = rx_valid && (state == DATA);
    assign word_cnt_inc = word_cnt + 1'b1;
    assign last_word    = (32'(word_cnt_inc) == 32'(n_words));

    im_loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_valid (data_xfer),
        .byte_in    (rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The outputs are decoded from the state alone. Because of this, reset
    // drops im_we, cpu_hold and rx_ready immediately, without waiting for
    // a clock edge.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        rx_ready   = 1'b0;
        im_we      = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (rx_valid) state_next = LEN_HI;
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    if (n_hdr == '0)                             state_next = DONE;
                    else if (n_hdr > (HDR_BYTES*8)'(DEPTH_WORDS)) state_next = ERROR;
                    else                                          state_next = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (word_ready) state_next = WRITE;
            end
            WRITE: begin
                im_we      = 1'b1;
                cpu_hold   = 1'b1;
                state_next = last_word ? DONE : DATA;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = LEN_LO;
            end
            ERROR: begin
                // Keep the core in reset so a rejected image never runs.
                error    = 1'b1;
                cpu_hold = 1'b1;
                if (start) state_next = LEN_LO;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_words  <= '0;
            word_cnt <= '0;
            im_addr  <= '0;
            im_wd    <= '0;
        end else begin
            if (start_ok)                     word_cnt       <= '0;
            if (state == LEN_LO && rx_valid)  n_words[7:0]   <= rx_data;
            if (state == LEN_HI && rx_valid)  n_words[15:8]  <= rx_data;
            if (word_ready) begin
                im_wd   <= word;
                im_addr <= {word_cnt, 2'b00};
            end
            if (state == WRITE)               word_cnt       <= word_cnt_inc;
        end
    end

endmodule
